// File: rtl/rr_arbiter_pkg.sv
// ============================================================================
// Module   : rr_arbiter_pkg
// Purpose  : Shared sizes, FSM state type and release-cause codes for the
//            eight-way round-robin arbiter.
// Contents : N_REQ, IDX_W, state_t {IDLE, BUSY}, REL_* release causes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Why a grant ended; used to classify observed releases.
  localparam logic [1:0] REL_DONE     = 2'd0;
  localparam logic [1:0] REL_WITHDRAW = 2'd1;
  localparam logic [1:0] REL_TIMEOUT  = 2'd2;
  localparam logic [1:0] REL_RESET    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational circular priority search. Starting at ptr_i and
//            walking ptr_i, ptr_i+1, ... (mod 8), selects the first set
//            request bit and reports it as one-hot and as a binary index.
// Ports    : req_i      [7:0] request vector
//            ptr_i      [2:0] highest-priority position this cycle
//            pick_o     [7:0] one-hot winner (zero when no request)
//            pick_idx_o [2:0] binary index of winner (zero when no request)
//            any_o            at least one request is set
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IDX_W-1:0] pick_idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] w_offset;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // Scan offsets from farthest to nearest so the nearest set bit (relative
  // to ptr_i) is the last writer and wins. The 3-bit sum wraps mod 8.
  always_comb begin
    w_offset = '0;
    w_found  = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[ptr_i + IDX_W'(i)]) begin
        w_offset = IDX_W'(i);
        w_found  = 1'b1;
      end
    end
  end

  assign w_idx      = ptr_i + w_offset;
  assign any_o      = w_found;
  assign pick_idx_o = w_found ? w_idx : '0;
  assign pick_o     = w_found ? (N_REQ'(1) << w_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_8.sv
// ============================================================================
// Module   : rr_arbiter_8
// Purpose  : Eight-way round-robin arbiter with registered one-hot grant,
//            encoded index and an optional hold timeout. A grant is held
//            until done, request withdrawal, or MAX_HOLD cycles elapse; each
//            grant is followed by a single IDLE bubble cycle.
// Params   : MAX_HOLD   max cycles a grant may be held (0 = no timeout)
// Ports    : clk              rising-edge clock
//            rst              synchronous active-high reset
//            req_i      [7:0] level-sensitive requests
//            done_i           completion pulse for the current grant
//            gnt_o      [7:0] one-hot grant
//            gnt_idx_o  [2:0] index of granted requester (0 when idle)
//            gnt_valid_o      grant active (|gnt_o)
//            timeout_o        one-cycle pulse after a timeout revoke
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_8
  import rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  // A zero MAX_HOLD would give a zero-width counter; keep one bit instead.
  localparam int c_CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit c_TIMER_EN = (MAX_HOLD != 0);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST =
      c_CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  state_t             state_q,   state_d;
  logic [IDX_W-1:0]   ptr_q,     ptr_d;
  logic [c_CNT_W-1:0] cnt_q,     cnt_d;
  logic [N_REQ-1:0]   gnt_q,     gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               timeout_q, timeout_d;

  logic [N_REQ-1:0]   w_pick;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_any;
  logic               w_withdrawn;
  logic               w_hold_expired;
  logic               w_release;

  rr_pick u_pick (
    .req_i      (req_i),
    .ptr_i      (ptr_q),
    .pick_o     (w_pick),
    .pick_idx_o (w_pick_idx),
    .any_o      (w_any)
  );

  assign w_withdrawn    = ~req_i[gnt_idx_q];
  assign w_hold_expired = c_TIMER_EN && (cnt_q == c_HOLD_LAST);
  assign w_release      = done_i | w_withdrawn | w_hold_expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_any) begin
          gnt_d     = w_pick;
          gnt_idx_d = w_pick_idx;
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        if (w_release) begin
          gnt_d     = '0;
          gnt_idx_d = '0;
          cnt_d     = '0;
          ptr_d     = gnt_idx_q + IDX_W'(1);
          state_d   = IDLE;
          // Only flag a timeout when the counter alone ended the grant;
          // done or withdrawal on the same edge take precedence.
          timeout_d = ~done_i & ~w_withdrawn;
        end else begin
          cnt_d = cnt_q + c_CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = |gnt_q;
  assign timeout_o   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
// ============================================================================
// Module   : tb_rr_arbiter_8
// Purpose  : Scoreboard bench for rr_arbiter_8 (MAX_HOLD=4). The stimulus
//            process queues the expected grant (index, length, release
//            cause); a monitor observes each completed grant and compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_8;
  import rr_arbiter_pkg::*;

  localparam int c_MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;
  int cov[4];

  typedef struct {
    logic [2:0] idx;
    int         len;
    logic [1:0] cause;
  } exp_t;

  exp_t exp_q[$];

  rr_arbiter_8 #(.MAX_HOLD(c_MAX_HOLD)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] idx, input int len, input logic [1:0] cause);
    exp_t e;
    e.idx   = idx;
    e.len   = len;
    e.cause = cause;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (gnt_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_grant: no grant within 20 cycles, req=%h", req);
    end
  endtask

  // Hold the grant for n BUSY cycles; with_done raises done in the last one.
  task automatic serve(input int n, input bit with_done);
    bit ok;
    wait_grant(ok);
    if (ok) begin
      for (int k = 1; k < n; k++) tick();
      done = with_done;
      tick();
      done = 1'b0;
    end
  endtask

  // Monitor: per-cycle output invariants plus per-grant scoreboard checks.
  initial begin
    bit         prev_valid = 1'b0;
    logic [7:0] start_gnt  = '0;
    logic [2:0] start_idx  = '0;
    int         len        = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      check("valid_is_or_gnt", int'(gnt_valid), int'(|gnt));
      if (gnt_valid)
        check("gnt_onehot_idx", int'(gnt), int'(8'b1 << gnt_idx));
      else
        check("idle_idx_zero", int'(gnt_idx), 0);

      if (gnt_valid && !prev_valid) begin
        start_gnt = gnt;
        start_idx = gnt_idx;
        len       = 1;
      end else if (gnt_valid && prev_valid) begin
        len++;
        check("gnt_stable", int'(gnt), int'(start_gnt));
      end

      if (!gnt_valid && prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got idx %0d len %0d, required none", start_idx, len);
        end else begin
          e = exp_q.pop_front();
          check("grant_idx", int'(start_idx), int'(e.idx));
          check("grant_len", len, e.len);
          check("timeout_pulse", int'(timeout), int'(e.cause == REL_TIMEOUT));
          cov[e.cause]++;
        end
      end else begin
        check("timeout_quiet", int'(timeout), 0);
      end
      prev_valid = gnt_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // Reset held two cycles with all requests asserted.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_gnt", int'(gnt), 0);
      check("rst_idx", int'(gnt_idx), 0);
      check("rst_valid", int'(gnt_valid), 0);
      check("rst_timeout", int'(timeout), 0);
    end
    rst = 1'b0;

    // First grant after reset goes to requester 0.
    push_exp(3'd0, 1, REL_DONE);
    serve(1, 1'b1);
    req = 8'h00;

    // Single requester 2, done in third BUSY cycle; ptr becomes 3.
    req = 8'h04;
    push_exp(3'd2, 3, REL_DONE);
    serve(3, 1'b1);
    req = 8'h00;

    // ptr=3: with bits 2 and 3 set, 3 is chosen first.
    req = 8'h0C;
    push_exp(3'd3, 1, REL_DONE);
    serve(1, 1'b1);
    req = 8'h00;

    // ptr=4: only bit 7 set -> grant 7, ptr wraps to 0.
    req = 8'h80;
    push_exp(3'd7, 1, REL_DONE);
    serve(1, 1'b1);

    // Full rotation with immediate done: 0..7 then 0 again.
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      push_exp(3'(i % 8), 1, REL_DONE);
      serve(1, 1'b1);
    end
    req = 8'h00;

    // ptr=1: grant 4, leaving ptr=5; then 0x11 must pick 0, not 4.
    req = 8'h10;
    push_exp(3'd4, 1, REL_DONE);
    serve(1, 1'b1);
    req = 8'h11;
    push_exp(3'd0, 1, REL_DONE);
    serve(1, 1'b1);
    req = 8'h00;

    // Timeout: held MAX_HOLD cycles, pulse in bubble, then re-grant where
    // done coincides with the last cycle and suppresses the pulse.
    req = 8'h02;
    push_exp(3'd1, c_MAX_HOLD, REL_TIMEOUT);
    serve(c_MAX_HOLD, 1'b0);
    push_exp(3'd1, c_MAX_HOLD, REL_DONE);
    serve(c_MAX_HOLD, 1'b1);
    req = 8'h00;

    // Withdrawal in the second BUSY cycle (ptr=2 -> grant 3).
    req = 8'h08;
    push_exp(3'd3, 2, REL_WITHDRAW);
    wait_grant(ok);
    if (ok) begin
      tick();
      req = 8'h00;
      tick();
    end

    // Reset in the second BUSY cycle (ptr=4 -> grant 6); ptr must return
    // to 0 so the following all-request grant is 0, not 7.
    req = 8'h40;
    push_exp(3'd6, 2, REL_RESET);
    wait_grant(ok);
    if (ok) begin
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    req = 8'hFF;
    push_exp(3'd0, 1, REL_DONE);
    serve(1, 1'b1);
    req = 8'h00;

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("release causes seen: done=%0d withdraw=%0d timeout=%0d reset=%0d",
             cov[REL_DONE], cov[REL_WITHDRAW], cov[REL_TIMEOUT], cov[REL_RESET]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
